// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: default instruction width, canonical NOP, PC width.
package riscv_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam int          PC_W         = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/ibuf_mem.sv
// DEPTH x W register-file storage: synchronous write, asynchronous read, no reset.
module ibuf_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_buf.sv
// Instruction prefetch FIFO between I-mem and decode; head is NOP when empty.
// Optional PC tagging of each entry is enabled with the IBUF_PC_TAG_EN macro.
module instr_buf
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [XLEN-1:0]        push_data,
`ifdef IBUF_PC_TAG_EN
    input  logic [PC_W-1:0]        push_pc,
    output logic [PC_W-1:0]        instr_pc,
`endif
    output logic                   full,
    input  logic                   pop,
    output logic [XLEN-1:0]        instr,
    output logic                   instr_valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             pop_ok, push_ok, we;
    logic [XLEN-1:0]  rd_data;

    // Status comes from the registered count only, so there is no push->valid bypass.
    assign instr_valid = (count != '0);
    assign full        = (count == CW'(DEPTH));
    assign pop_ok      = pop & instr_valid;
    assign push_ok     = push & (~full | pop_ok);
    assign we          = push_ok & ~flush & rst;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    ibuf_mem #(.DEPTH(DEPTH), .W(XLEN)) u_data (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (push_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign instr = instr_valid ? rd_data : XLEN'(NOP_INSTR);

`ifdef IBUF_PC_TAG_EN
    logic [PC_W-1:0] rd_pc;

    ibuf_mem #(.DEPTH(DEPTH), .W(PC_W)) u_pc (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (push_pc),
        .raddr (rd_ptr),
        .rdata (rd_pc)
    );

    assign instr_pc = instr_valid ? rd_pc : '0;
`endif

endmodule

// File: doc/instr_buf.md
INSTR_BUF -- requirements
Module: instr_buf

Interface
REQ-001 Parameter XLEN, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 4, number of buffered instructions; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; asserted when rst==0.
REQ-005 flush  input  1  discard all buffered entries (branch/jump redirect).
REQ-006 push  input  1  write push_data this cycle; ignored when full==1 unless pop==1 in the same cycle.
REQ-007 push_data  input  XLEN  instruction word from instruction memory.
REQ-008 push_pc  input  32  PC of push_data; present only with IBUF_PC_TAG_EN.
REQ-009 full  output  1  no free entry; count==DEPTH.
REQ-010 pop  input  1  consumer takes the head entry; ignored when instr_valid==0.
REQ-011 instr  output  XLEN  head instruction.
REQ-012 instr_pc  output  32  PC of head; present only with IBUF_PC_TAG_EN.
REQ-013 instr_valid  output  1  head entry is valid.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-015 Circular FIFO storage: read and write pointers of $clog2(DEPTH) bits each; pointers wrap from DEPTH-1 to 0.
REQ-016 Accepted push writes storage[wr_ptr], then increments wr_ptr and count.
REQ-017 Accepted pop increments rd_ptr and decrements count.
REQ-018 Push and pop accepted in the same cycle: both pointers advance and count is unchanged; this applies when full, and when count==1.
REQ-019 Push into an empty buffer: instr_valid=1 and instr=push_data on the next cycle (1-cycle latency); no combinational bypass.
REQ-020 instr shall be storage[rd_ptr] when instr_valid==1, and the NOP constant (0x00000013) when instr_valid==0.
REQ-021 instr_valid shall equal (count!=0); full shall equal (count==DEPTH); both are derived from registered count only.
REQ-022 Push when full without a simultaneous pop: the push is dropped and state is unchanged.
REQ-023 Pop when empty: ignored and state is unchanged.
REQ-024 flush has priority over push and pop in the same cycle: next cycle count=0, rd_ptr=wr_ptr=0, and push_data from the flush cycle is not stored.
REQ-025 Storage contents are not cleared by flush or reset; visibility is controlled solely by count.

Reset
REQ-026 While rst==0 at a rising edge: count=0, rd_ptr=0, wr_ptr=0; next cycle instr_valid=0, full=0, instr=NOP, instr_pc=0.
REQ-027 Reset overrides flush, push and pop; reset mid-stream discards all entries.
REQ-028 Storage arrays have no reset.

Configuration
REQ-029 Macro IBUF_PC_TAG_EN defined: push_pc and instr_pc ports exist, a 32-bit PC array parallel to the data array is stored, and instr_pc=pc_storage[rd_ptr] when valid, else 0.
REQ-030 Macro IBUF_PC_TAG_EN undefined: the push_pc and instr_pc ports and the PC array are absent; all other behaviour is identical.

Structure
REQ-031 Shared package riscv_pkg holds XLEN default, the NOP encoding constant (32'h00000013), and the PC width (32).
REQ-032 Single natural sub-module ibuf_mem: DEPTH x W storage with synchronous write and asynchronous read, instantiated once for data and once for PC when IBUF_PC_TAG_EN is defined.
REQ-033 Pointer and count logic stays in instr_buf.

Verification
REQ-034 Reset, then push 0x00500093 -> next cycle instr_valid=1, instr=0x00500093, count=1.
REQ-035 Push 4 words (DEPTH=4) without pop -> full=1, count=4; a 5th push 0xDEADBEEF is dropped; pop order matches push order.
REQ-036 Full buffer with push and pop in the same cycle -> count stays 4, full stays 1, new word appears after the 3 older ones.
REQ-037 3 entries, then flush with simultaneous push and pop -> next cycle count=0, instr_valid=0, instr=0x00000013.
REQ-038 Run 10 push/pop pairs to exercise pointer wrap -> data integrity holds across the wrap; with IBUF_PC_TAG_EN, instr_pc tracks push_pc (0x100, 0x104, ...).
REQ-039 rst=0 asserted mid-stream with count=2 -> next cycle count=0, instr_valid=0; pop while empty leaves count=0.
